// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared sizing for the CDB arbiter slice.
// Default lane/source counts, widths and the pointer-width helper.
package cdb_arbiter_pkg;

    localparam int CDB_N       = 2;
    localparam int CDB_NUM_REQ = 4;
    localparam int CDB_TAG_W   = 6;
    localparam int CDB_DATA_W  = 32;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    // A one-source arbiter still needs a 1-bit pointer vector.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_rr_select.sv
// cdb_rr_select: picks up to N requests, searching upward from ptr (mod NUM_REQ).
// Ports: req/ptr in; gnt, per-lane valid + source index, last winner, any out.
module cdb_rr_select
    import cdb_arbiter_pkg::*;
#(
    parameter int N       = CDB_N,
    parameter int NUM_REQ = CDB_NUM_REQ,
    parameter int PW      = ptr_width(CDB_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [N-1:0]       lane_vld,
    output logic [N*PW-1:0]    lane_src,
    output logic [PW-1:0]      last,
    output logic               any
);

    int idx;
    int cnt;

    // Walking the rotated request vector in order is the same as rotate,
    // priority-select N, rotate back; the k-th hit lands on lane k.
    always_comb begin
        gnt      = '0;
        lane_vld = '0;
        lane_src = '0;
        last     = '0;
        idx      = 0;
        cnt      = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = j + int'(ptr);
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx] && cnt < N) begin
                gnt[idx]                = 1'b1;
                lane_vld[cnt]           = 1'b1;
                lane_src[cnt*PW +: PW]  = PW'(idx);
                last                    = PW'(idx);
                cnt                     = cnt + 1;
            end
        end
        any = |gnt;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants up to N result sources per cycle onto registered CDB lanes.
// Ports: clock, reset_n (async low), flush; req_valid/tag/data in, req_ready out;
// cdb_valid/tag/data registered out; stall_count saturating denied-cycle count.
// Build option CDB_ARB_RR_EN: rotating-pointer fairness; otherwise fixed priority.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N       = CDB_N,
    parameter int NUM_REQ = CDB_NUM_REQ,
    parameter int TAG_W   = CDB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [N-1:0]              cdb_valid,
    output logic [N*TAG_W-1:0]        cdb_tag,
    output logic [N*DATA_W-1:0]       cdb_data,
    output logic [15:0]               stall_count
);

    localparam int PW = ptr_width(NUM_REQ);

    logic [PW-1:0]      ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [N-1:0]       lane_vld;
    logic [N*PW-1:0]    lane_src;
    logic [PW-1:0]      last;
    logic               any;

    logic [N-1:0]        nxt_valid;
    logic [N*TAG_W-1:0]  nxt_tag;
    logic [N*DATA_W-1:0] nxt_data;
    logic                stall_inc;

    cdb_rr_select #(
        .N       (N),
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_sel (
        .req      (req_valid),
        .ptr      (ptr),
        .gnt      (gnt),
        .lane_vld (lane_vld),
        .lane_src (lane_src),
        .last     (last),
        .any      (any)
    );

`ifdef CDB_ARB_RR_EN
    logic [PW-1:0] ptr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (!flush && any) begin
            if (last == PW'(NUM_REQ - 1)) ptr_q <= '0;
            else                          ptr_q <= last + 1'b1;
        end
    end

    assign ptr = ptr_q;
`else
    logic unused_sel;

    assign ptr        = '0;
    assign unused_sel = ^{last, any};
`endif

    // Ready is squashed during flush and while reset is held.
    assign req_ready = (reset_n && !flush) ? gnt : '0;

    always_comb begin
        nxt_valid = '0;
        nxt_tag   = '0;
        nxt_data  = '0;
        for (int k = 0; k < N; k++) begin
            if (lane_vld[k] && !flush) begin
                nxt_valid[k] = 1'b1;
                nxt_tag[k*TAG_W +: TAG_W] =
                    req_tag[int'(lane_src[k*PW +: PW])*TAG_W +: TAG_W];
                nxt_data[k*DATA_W +: DATA_W] =
                    req_data[int'(lane_src[k*PW +: PW])*DATA_W +: DATA_W];
            end
        end
    end

    // gnt is a subset of req_valid, so any leftover valid bit is a denial.
    assign stall_inc = !flush && (|(req_valid & ~gnt))
                       && (stall_count != STALL_MAX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cdb_valid   <= '0;
            cdb_tag     <= '0;
            cdb_data    <= '0;
            stall_count <= '0;
        end else begin
            cdb_valid <= nxt_valid;
            cdb_tag   <= nxt_tag;
            cdb_data  <= nxt_data;
            if (stall_inc) stall_count <= stall_count + 16'd1;
        end
    end

endmodule
